// File: rtl/microtile_pkg.sv
// rtl/microtile_pkg.sv - shared constants, state type and helpers for the microtile sequencer
// Purpose: tile geometry constants (config chain length, ring phases), the
//          sequencer state encoding, and small elaboration/runtime helpers.
// Ports:   none (package).
package microtile_pkg;

  localparam int CFG_BITS = 20;
  localparam int PHASES   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Out-of-range entry counts are folded into 1..depth so the round-robin
  // index never walks off the end of the bank.
  function automatic int clamp_num_pat(input int num, input int depth);
    if (num < 1) return 1;
    if (num > depth) return depth;
    return num;
  endfunction

endpackage

// File: rtl/microtile_pattern_bank.sv
// rtl/microtile_pattern_bank.sv - DEPTH x 20 pattern register array
// Purpose: holds host-written pin patterns; contents are undefined until written.
// Ports:   clk      - clock
//          wr_en    - write strobe (host valid && ready)
//          wr_addr  - entry to write
//          wr_data  - pattern word
//          rd_addr  - asynchronous read address
//          rd_data  - pattern word at rd_addr
module microtile_pattern_bank
  import microtile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [CFG_BITS-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [CFG_BITS-1:0] rd_data
);

  logic [CFG_BITS-1:0] mem_q [DEPTH];

  // No reset: the bank is plain storage and software always writes before use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/microtile_pattern_sequencer.sv
// rtl/microtile_pattern_sequencer.sv - loads and plays bank patterns on the pin-scan microtile
// Purpose: serially loads a 20-bit pattern into the tile chain (run low), then
//          runs the 5-phase ring (run high) for dwell revolutions, round-robin
//          over num_pat bank entries.
// Ports:   clk, rst_n           - clock, synchronous active-low reset
//          enable               - start/continue sequencing
//          wr_valid/ready/addr/data - host bank write port
//          num_pat, dwell       - entries to cycle, revolutions per pattern
//          cfg_sdata, cfg_run   - tile serial data and run line
//          pat_idx, loading     - current entry, high during LOAD
module microtile_pattern_sequencer
  import microtile_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 8,
  localparam int AW  = clog2(DEPTH),
  localparam int AW1 = AW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [AW-1:0]       wr_addr,
  input  logic [CFG_BITS-1:0] wr_data,
  input  logic [AW:0]         num_pat,
  input  logic [DWELL_W-1:0]  dwell,
  output logic                cfg_sdata,
  output logic                cfg_run,
  output logic [AW-1:0]       pat_idx,
  output logic                loading
);

  seq_state_t          state_q, state_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [2:0]          phase_q, phase_d;
  logic [DWELL_W-1:0]  revs_q, revs_d;
  logic [CFG_BITS-1:0] shreg_q, shreg_d;
  logic [AW-1:0]       pat_idx_q, pat_idx_d;

  logic                start;
  logic                rev_end;
  logic                advance;
  logic [AW:0]         n_eff;
  logic [AW:0]         idx_inc;
  logic [AW-1:0]       idx_next;
  logic [CFG_BITS-1:0] rd_data;

  assign wr_ready = 1'b1;

  // The bank is read at the index being entered, so the word latched on the
  // LOAD-entry edge belongs to the new entry. A write on that same edge lands
  // after the read, so the old word is what gets shifted.
  microtile_pattern_bank #(.DEPTH(DEPTH)) u_bank (
    .clk     (clk),
    .wr_en   (wr_valid & wr_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (pat_idx_d),
    .rd_data (rd_data)
  );

  // Index selection lives apart from the FSM body so the bank read address
  // does not feed back into the block that consumes rd_data.
  always_comb begin
    start    = (state_q == IDLE) && enable;
    rev_end  = (state_q == RUN) && (phase_q == 3'(PHASES - 1));
    advance  = rev_end && enable && (dwell != '0) &&
               ((revs_q + DWELL_W'(1)) == dwell);
    n_eff    = AW1'(clamp_num_pat(int'(num_pat), DEPTH));
    idx_inc  = {1'b0, pat_idx_q} + AW1'(1);
    idx_next = (idx_inc >= n_eff) ? '0 : idx_inc[AW-1:0];
    pat_idx_d = pat_idx_q;
    if (start) begin
      pat_idx_d = '0;
    end else if (advance) begin
      pat_idx_d = idx_next;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    revs_d    = revs_q;
    shreg_d   = shreg_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          bit_cnt_d = '0;
          shreg_d   = rd_data;
        end
      end
      LOAD: begin
        shreg_d   = {shreg_q[CFG_BITS-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'(CFG_BITS - 1)) begin
          // The load always completes; enable only chooses where to go after.
          state_d = enable ? RUN : IDLE;
          phase_d = '0;
          revs_d  = '0;
        end
      end
      RUN: begin
        if (rev_end) begin
          phase_d = '0;
          if (!enable) begin
            state_d = IDLE;
          end else if (advance) begin
            state_d   = LOAD;
            bit_cnt_d = '0;
            shreg_d   = rd_data;
            revs_d    = '0;
          end else begin
            revs_d = revs_q + DWELL_W'(1);
          end
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      phase_q   <= '0;
      revs_q    <= '0;
      shreg_q   <= '0;
      pat_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      revs_q    <= revs_d;
      shreg_q   <= shreg_d;
      pat_idx_q <= pat_idx_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them on
  // the same edge and the chain sees zeros whenever it is not loading.
  assign cfg_run   = (state_q == RUN);
  assign loading   = (state_q == LOAD);
  assign cfg_sdata = (state_q == LOAD) ? shreg_q[CFG_BITS-1] : 1'b0;
  assign pat_idx   = pat_idx_q;

endmodule

// File: tb/tb_microtile_pattern_sequencer.sv
// tb/tb_microtile_pattern_sequencer.sv - directed scoreboard bench for microtile_pattern_sequencer
module tb_microtile_pattern_sequencer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_addr;
  logic [19:0] wr_data;
  logic [2:0]  num_pat;
  logic [7:0]  dwell;
  logic        cfg_sdata;
  logic        cfg_run;
  logic [1:0]  pat_idx;
  logic        loading;

  int vectors;
  int miscompares;

  typedef struct packed {
    logic       run;
    logic       sdata;
    logic [1:0] idx;
    logic       load;
  } obs_t;

  obs_t exp_q[$];

  microtile_pattern_sequencer #(.DEPTH(4), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .num_pat   (num_pat),
    .dwell     (dwell),
    .cfg_sdata (cfg_sdata),
    .cfg_run   (cfg_run),
    .pat_idx   (pat_idx),
    .loading   (loading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_load(input logic [19:0] word, input logic [1:0] idx);
    for (int i = 19; i >= 0; i--) begin
      exp_q.push_back('{run: 1'b0, sdata: word[i], idx: idx, load: 1'b1});
    end
  endtask

  task automatic push_run(input int n, input logic [1:0] idx);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{run: 1'b1, sdata: 1'b0, idx: idx, load: 1'b0});
    end
  endtask

  task automatic push_idle(input int n, input logic [1:0] idx);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{run: 1'b0, sdata: 1'b0, idx: idx, load: 1'b0});
    end
  endtask

  // Pops at most n expected entries, one per cycle, sampling at the negedge.
  task automatic drain(input int n, input string tag);
    obs_t expv;
    obs_t obs;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      @(negedge clk);
      expv = exp_q.pop_front();
      obs  = '{run: cfg_run, sdata: cfg_sdata, idx: pat_idx, load: loading};
      vectors++;
      assert (obs === expv) else begin
        miscompares++;
        $error("FAIL %s cycle %0d: observed run/sd/idx/ld=%b/%b/%0d/%b expected %b/%b/%0d/%b",
               tag, i, obs.run, obs.sdata, obs.idx, obs.load,
               expv.run, expv.sdata, expv.idx, expv.load);
      end
    end
  endtask

  task automatic bank_write(input logic [1:0] addr, input logic [19:0] data);
    wr_valid = 1'b1;
    wr_addr  = addr;
    wr_data  = data;
    check_val("wr_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic enter_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b0;
    enable   = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    num_pat  = 3'd1;
    dwell    = 8'd1;

    // Reset held 3 cycles with enable high.
    repeat (3) @(negedge clk);
    check_val("rst_cfg_run", 32'(cfg_run), 32'd0);
    check_val("rst_cfg_sdata", 32'(cfg_sdata), 32'd0);
    check_val("rst_pat_idx", 32'(pat_idx), 32'd0);
    check_val("rst_loading", 32'(loading), 32'd0);
    check_val("rst_wr_ready", 32'(wr_ready), 32'd1);

    // Single load, reloaded after one revolution.
    enable = 1'b0;
    bank_write(2'd0, 20'hA5F0C);
    num_pat = 3'd1;
    dwell   = 8'd1;
    rst_n   = 1'b1;
    push_idle(3, 2'd0);
    drain(3, "idle_hold");
    enable = 1'b1;
    push_load(20'hA5F0C, 2'd0);
    push_run(5, 2'd0);
    push_load(20'hA5F0C, 2'd0);
    push_run(5, 2'd0);
    drain(50, "single_load");

    // Rotation over two entries, two revolutions each.
    enter_reset();
    bank_write(2'd0, 20'h00001);
    bank_write(2'd1, 20'hFFFFF);
    num_pat = 3'd2;
    dwell   = 8'd2;
    rst_n   = 1'b1;
    enable  = 1'b1;
    push_load(20'h00001, 2'd0);
    push_run(10, 2'd0);
    push_load(20'hFFFFF, 2'd1);
    push_run(10, 2'd1);
    push_load(20'h00001, 2'd0);
    push_run(10, 2'd0);
    drain(90, "rotation");

    // dwell=0 holds the first pattern indefinitely.
    enter_reset();
    num_pat = 3'd2;
    dwell   = 8'd0;
    rst_n   = 1'b1;
    enable  = 1'b1;
    push_load(20'h00001, 2'd0);
    push_run(200, 2'd0);
    drain(220, "hold");

    // num_pat above DEPTH clamps to DEPTH: entries 0,1,2,3 then back to 0.
    enter_reset();
    bank_write(2'd2, 20'h3C3C3);
    bank_write(2'd3, 20'h80001);
    num_pat = 3'd7;
    dwell   = 8'd1;
    rst_n   = 1'b1;
    enable  = 1'b1;
    push_load(20'h00001, 2'd0);
    push_run(5, 2'd0);
    push_load(20'hFFFFF, 2'd1);
    push_run(5, 2'd1);
    push_load(20'h3C3C3, 2'd2);
    push_run(5, 2'd2);
    push_load(20'h80001, 2'd3);
    push_run(5, 2'd3);
    push_load(20'h00001, 2'd0);
    drain(120, "clamp_depth");

    // num_pat=0 acts as 1: the same entry reloads.
    enter_reset();
    num_pat = 3'd0;
    dwell   = 8'd1;
    rst_n   = 1'b1;
    enable  = 1'b1;
    push_load(20'h00001, 2'd0);
    push_run(5, 2'd0);
    push_load(20'h00001, 2'd0);
    drain(45, "num_pat_zero");

    // Enable dropped at bit 7 of a load: the rest shifts out, then IDLE.
    enter_reset();
    bank_write(2'd0, 20'hA5F0C);
    num_pat = 3'd1;
    dwell   = 8'd1;
    rst_n   = 1'b1;
    enable  = 1'b1;
    push_load(20'hA5F0C, 2'd0);
    push_idle(5, 2'd0);
    drain(7, "drop_load_head");
    enable = 1'b0;
    drain(18, "drop_load_tail");

    // Enable dropped at phase 2 of a revolution: phases 3,4 run, then IDLE.
    enter_reset();
    num_pat = 3'd1;
    dwell   = 8'd3;
    rst_n   = 1'b1;
    enable  = 1'b1;
    push_load(20'hA5F0C, 2'd0);
    push_run(8, 2'd0);
    push_run(2, 2'd0);
    push_idle(4, 2'd0);
    drain(28, "drop_run_head");
    enable = 1'b0;
    drain(6, "drop_run_tail");

    // Write to entry 1 on its LOAD-entry edge: old word now, new word next visit.
    enter_reset();
    bank_write(2'd0, 20'h12345);
    bank_write(2'd1, 20'h0F0F0);
    num_pat = 3'd2;
    dwell   = 8'd1;
    rst_n   = 1'b1;
    enable  = 1'b1;
    push_load(20'h12345, 2'd0);
    push_run(5, 2'd0);
    push_load(20'h0F0F0, 2'd1);
    push_run(5, 2'd1);
    push_load(20'h12345, 2'd0);
    push_run(5, 2'd0);
    push_load(20'hCAFE5, 2'd1);
    drain(25, "collide_pre");
    wr_valid = 1'b1;
    wr_addr  = 2'd1;
    wr_data  = 20'hCAFE5;
    drain(1, "collide_edge");
    wr_valid = 1'b0;
    drain(100, "collide_post");

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
